// File: rtl/debug_pkg.sv
// Shared types and constants for the debug-port program loader.
package debug_pkg;
  typedef enum logic [2:0] {IDLE, ADDR, LEN, DATA, DONE} loader_state_t;
  localparam logic [7:0] SYNC_BYTE_DEF   = 8'hA5;
  localparam int         FRAME_HDR_BYTES = 7;
endpackage

// File: rtl/byte_assembler.sv
// Little-endian field assembler: collects N_BYTES bytes, byte k lands in bits [8k+7:8k].
module byte_assembler #(
  parameter int N_BYTES = 4
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_clr,
  input  logic                   i_en,
  input  logic [7:0]             i_byte,
  output logic [8*N_BYTES-1:0]   o_word,
  output logic                   o_last
);
  localparam int IW = (N_BYTES > 1) ? $clog2(N_BYTES) : 1;

  logic [IW-1:0]          r_idx;
  logic [8*N_BYTES-1:0]   r_word;

  // o_word already includes the byte on i_byte so the owner can act on the completing cycle.
  always_comb begin
    o_word = r_word;
    o_word[8*r_idx +: 8] = i_byte;
  end

  assign o_last = i_en && (r_idx == IW'(N_BYTES-1));

  always_ff @(posedge i_clk) begin
    if (i_rst || i_clr) begin
      r_idx  <= '0;
      r_word <= '0;
    end else if (i_en) begin
      r_word <= o_word;
      r_idx  <= o_last ? '0 : r_idx + 1'b1;
    end
  end
endmodule

// File: rtl/debug_loader.sv
// Parses framed load packets from the host byte stream and writes the core's
// instruction memory through the debug port while holding the core.
module debug_loader
  import debug_pkg::*;
#(
  parameter logic [7:0] SYNC_BYTE      = SYNC_BYTE_DEF,
  parameter int         TIMEOUT_CYCLES = 100000,
  parameter int         ADDR_W         = 32
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_rx_valid,
  input  logic [7:0]        i_rx_data,
  output logic              o_rx_ready,
  output logic              o_debug_sig,
  output logic [ADDR_W-1:0] o_debug_addr,
  output logic [31:0]       o_debug_instr,
  output logic              o_debug_we,
  output logic              o_load_done,
  output logic              o_err_align,
  output logic              o_err_timeout,
  output logic [15:0]       o_words_left
);
  localparam int GW = $clog2(TIMEOUT_CYCLES + 1);

  loader_state_t     r_state;
  logic [GW-1:0]     r_gap;
  logic [ADDR_W-1:0] r_cur_addr, r_addr;
  logic [31:0]       r_instr;
  logic [15:0]       r_words_left;
  logic              r_sig, r_we, r_done, r_err_align, r_err_timeout;

  logic              w_acc, w_in_frame, w_timeout, w_clr;
  logic [31:0]       w_addr_word, w_data_word;
  logic [15:0]       w_len_word;
  logic              w_addr_last, w_len_last, w_data_last;

  assign o_rx_ready = (r_state != DONE);
  assign w_acc      = i_rx_valid && o_rx_ready;
  assign w_in_frame = r_state inside {ADDR, LEN, DATA};
  assign w_timeout  = w_in_frame && !w_acc && (r_gap == GW'(TIMEOUT_CYCLES - 1));
  // Assemblers sit cleared while idle, so every frame starts at byte 0 and a
  // partial word left by an abort is discarded.
  assign w_clr      = (r_state == IDLE);

  byte_assembler #(.N_BYTES(4)) u_addr (
    .i_clk(i_clk), .i_rst(i_rst), .i_clr(w_clr),
    .i_en(w_acc && r_state == ADDR), .i_byte(i_rx_data),
    .o_word(w_addr_word), .o_last(w_addr_last)
  );

  byte_assembler #(.N_BYTES(2)) u_len (
    .i_clk(i_clk), .i_rst(i_rst), .i_clr(w_clr),
    .i_en(w_acc && r_state == LEN), .i_byte(i_rx_data),
    .o_word(w_len_word), .o_last(w_len_last)
  );

  byte_assembler #(.N_BYTES(4)) u_data (
    .i_clk(i_clk), .i_rst(i_rst), .i_clr(w_clr),
    .i_en(w_acc && r_state == DATA), .i_byte(i_rx_data),
    .o_word(w_data_word), .o_last(w_data_last)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state       <= IDLE;
      r_gap         <= '0;
      r_cur_addr    <= '0;
      r_addr        <= '0;
      r_instr       <= '0;
      r_words_left  <= '0;
      r_sig         <= 1'b0;
      r_we          <= 1'b0;
      r_done        <= 1'b0;
      r_err_align   <= 1'b0;
      r_err_timeout <= 1'b0;
    end else begin
      r_we   <= 1'b0;
      r_done <= 1'b0;
      if (w_in_frame) r_gap <= w_acc ? '0 : r_gap + 1'b1;
      else            r_gap <= '0;

      case (r_state)
        IDLE: if (w_acc && i_rx_data == SYNC_BYTE) begin
          r_state       <= ADDR;
          r_sig         <= 1'b1;
          r_err_align   <= 1'b0;
          r_err_timeout <= 1'b0;
        end
        ADDR: if (w_addr_last) begin
          if (w_addr_word[1:0] != 2'b00) begin
            r_err_align <= 1'b1;
            r_sig       <= 1'b0;
            r_state     <= IDLE;
          end else begin
            r_cur_addr <= ADDR_W'(w_addr_word);
            r_state    <= LEN;
          end
        end
        LEN: if (w_len_last) begin
          r_words_left <= w_len_word;
          r_state      <= (w_len_word == 16'd0) ? DONE : DATA;
        end
        DATA: if (w_data_last) begin
          r_instr      <= w_data_word;
          r_addr       <= r_cur_addr;
          r_we         <= 1'b1;
          r_cur_addr   <= r_cur_addr + ADDR_W'(4);
          r_words_left <= r_words_left - 16'd1;
          if (r_words_left == 16'd1) r_state <= DONE;
        end
        DONE: begin
          r_sig   <= 1'b0;
          r_done  <= 1'b1;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase

      if (w_timeout) begin
        r_err_timeout <= 1'b1;
        r_sig         <= 1'b0;
        r_state       <= IDLE;
      end
    end
  end

  assign o_debug_sig   = r_sig;
  assign o_debug_addr  = r_addr;
  assign o_debug_instr = r_instr;
  assign o_debug_we    = r_we;
  assign o_load_done   = r_done;
  assign o_err_align   = r_err_align;
  assign o_err_timeout = r_err_timeout;
  assign o_words_left  = r_words_left;
endmodule

// File: tb/tb_debug_loader.sv
// Directed frames against debug_loader; write strobes and done pulses are
// checked by a monitor against an expectation queue.
module tb_debug_loader;
  logic        i_clk = 1'b0;
  logic        i_rst;
  logic        i_rx_valid;
  logic [7:0]  i_rx_data;
  logic        o_rx_ready, o_debug_sig, o_debug_we, o_load_done;
  logic        o_err_align, o_err_timeout;
  logic [31:0] o_debug_addr, o_debug_instr;
  logic [15:0] o_words_left;

  typedef struct {
    bit          is_done;
    logic [31:0] addr;
    logic [31:0] instr;
  } ev_t;

  ev_t exp_q[$];
  int  n_vec = 0;
  int  n_err = 0;

  debug_loader #(.SYNC_BYTE(8'hA5), .TIMEOUT_CYCLES(16), .ADDR_W(32)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_rx_valid(i_rx_valid), .i_rx_data(i_rx_data),
    .o_rx_ready(o_rx_ready), .o_debug_sig(o_debug_sig), .o_debug_addr(o_debug_addr),
    .o_debug_instr(o_debug_instr), .o_debug_we(o_debug_we), .o_load_done(o_load_done),
    .o_err_align(o_err_align), .o_err_timeout(o_err_timeout), .o_words_left(o_words_left)
  );

  always #5 i_clk = ~i_clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic exp_wr(input logic [31:0] a, input logic [31:0] d);
    ev_t e;
    e.is_done = 1'b0; e.addr = a; e.instr = d;
    exp_q.push_back(e);
  endtask

  task automatic exp_done();
    ev_t e;
    e.is_done = 1'b1; e.addr = '0; e.instr = '0;
    exp_q.push_back(e);
  endtask

  // Monitor: sample mid-cycle, pop one expectation per strobe.
  always @(negedge i_clk) begin
    if (!i_rst && (o_debug_we || o_load_done)) begin
      if (exp_q.size() == 0) begin
        chk(o_debug_we ? "unexpected_we" : "unexpected_done", 32'd1, 32'd0);
      end else begin
        ev_t e;
        e = exp_q.pop_front();
        if (e.is_done) begin
          chk("done_pulse", {31'd0, o_load_done}, 32'd1);
          chk("done_we_clear", {31'd0, o_debug_we}, 32'd0);
        end else begin
          chk("we_pulse", {31'd0, o_debug_we}, 32'd1);
          chk("we_addr", o_debug_addr, e.addr);
          chk("we_instr", o_debug_instr, e.instr);
        end
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge i_clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b);
    int n;
    n = 0;
    i_rx_valid = 1'b1;
    i_rx_data  = b;
    while (!o_rx_ready && n < 50) begin
      @(posedge i_clk); #1; n++;
    end
    if (n >= 50) chk("ready_wait", 32'd0, 32'd1);
    @(posedge i_clk); #1;
  endtask

  task automatic send32(input logic [31:0] w);
    for (int k = 0; k < 4; k++) send(w[8*k +: 8]);
  endtask

  task automatic send16(input logic [15:0] w);
    send(w[7:0]);
    send(w[15:8]);
  endtask

  task automatic idle();
    i_rx_valid = 1'b0;
  endtask

  initial begin
    int n;
    i_rst = 1'b1; i_rx_valid = 1'b0; i_rx_data = 8'h00;
    cyc(3);
    i_rst = 1'b0;
    cyc(1);
    chk("rst_ready", {31'd0, o_rx_ready}, 32'd1);
    chk("rst_sig", {31'd0, o_debug_sig}, 32'd0);
    chk("rst_we", {31'd0, o_debug_we}, 32'd0);
    chk("rst_errs", {30'd0, o_err_align, o_err_timeout}, 32'd0);
    chk("rst_words", {16'd0, o_words_left}, 32'd0);
    chk("rst_addr", o_debug_addr, 32'd0);

    // Single aligned word
    send(8'hA5);
    chk("t1_sig_held", {31'd0, o_debug_sig}, 32'd1);
    send32(32'h0000_1000);
    send16(16'd1);
    chk("t1_words", {16'd0, o_words_left}, 32'd1);
    exp_wr(32'h0000_1000, 32'h0010_0513);
    exp_done();
    send32(32'h0010_0513);
    idle();
    chk("t1_sig_during_done", {31'd0, o_debug_sig}, 32'd1);
    chk("t1_ready_in_done", {31'd0, o_rx_ready}, 32'd0);
    cyc(1);
    chk("t1_sig_drop", {31'd0, o_debug_sig}, 32'd0);
    chk("t1_words_end", {16'd0, o_words_left}, 32'd0);
    cyc(2);

    // Three words back-to-back from 0
    send(8'hA5);
    send32(32'h0);
    send16(16'd3);
    chk("t2_words3", {16'd0, o_words_left}, 32'd3);
    exp_wr(32'h0, 32'h1111_2222);
    exp_wr(32'h4, 32'h3333_4444);
    exp_wr(32'h8, 32'h5555_6666);
    exp_done();
    send32(32'h1111_2222);
    chk("t2_words2", {16'd0, o_words_left}, 32'd2);
    send32(32'h3333_4444);
    chk("t2_words1", {16'd0, o_words_left}, 32'd1);
    send32(32'h5555_6666);
    chk("t2_words0", {16'd0, o_words_left}, 32'd0);
    idle();
    cyc(3);
    chk("t2_sig_drop", {31'd0, o_debug_sig}, 32'd0);

    // Misaligned address aborts
    send(8'hA5);
    send32(32'h0000_1002);
    idle();
    chk("t3_err_align", {31'd0, o_err_align}, 32'd1);
    chk("t3_sig_drop", {31'd0, o_debug_sig}, 32'd0);
    cyc(2);

    // len = 0 frame, also clears err_align
    send(8'hA5);
    chk("t4_align_cleared", {31'd0, o_err_align}, 32'd0);
    send32(32'h0000_2000);
    exp_done();
    send16(16'd0);
    idle();
    chk("t4_sig_in_done", {31'd0, o_debug_sig}, 32'd1);
    cyc(1);
    chk("t4_sig_drop", {31'd0, o_debug_sig}, 32'd0);
    cyc(2);

    // Stall after two data bytes
    send(8'hA5);
    send32(32'h0000_3000);
    send16(16'd1);
    send(8'hAA);
    send(8'hBB);
    idle();
    cyc(20);
    chk("t5_err_timeout", {31'd0, o_err_timeout}, 32'd1);
    chk("t5_sig_drop", {31'd0, o_debug_sig}, 32'd0);
    chk("t5_ready", {31'd0, o_rx_ready}, 32'd1);

    // Garbage then frame wrapping at top of address space
    send(8'h00);
    send(8'hFF);
    chk("t6_garbage_ignored", {31'd0, o_debug_sig}, 32'd0);
    send(8'hA5);
    chk("t6_timeout_cleared", {31'd0, o_err_timeout}, 32'd0);
    send32(32'hFFFF_FFFC);
    send16(16'd2);
    exp_wr(32'hFFFF_FFFC, 32'h1122_3344);
    exp_wr(32'h0000_0000, 32'hDEAD_BEEF);
    exp_done();
    send32(32'h1122_3344);
    send32(32'hDEAD_BEEF);
    idle();
    cyc(3);
    chk("t6_hold_addr", o_debug_addr, 32'h0000_0000);
    chk("t6_hold_instr", o_debug_instr, 32'hDEAD_BEEF);

    // Reset mid-word: no partial write, back to reset values
    send(8'hA5);
    send32(32'h0000_4000);
    send16(16'd1);
    send(8'h01);
    send(8'h02);
    idle();
    i_rst = 1'b1;
    cyc(2);
    i_rst = 1'b0;
    cyc(2);
    chk("t7_sig_reset", {31'd0, o_debug_sig}, 32'd0);
    chk("t7_words_reset", {16'd0, o_words_left}, 32'd0);
    chk("t7_instr_reset", o_debug_instr, 32'd0);

    n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      cyc(1); n++;
    end
    chk("pending_events", exp_q.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
